// File: rtl/prng_rnd_feeder.sv
// Collects W-bit PRNG beats into RND-bit randomness entries held in a two-entry ping-pong buffer; each entry is shown to the masked core exactly once.
// Optional build macro RND_FEEDER_ZEROIZE_EN: clear spent or flushed entries and blank rnd_out while nothing valid is held.
module prng_rnd_feeder #(
    parameter int RND = 128,
    parameter int W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prng_out_valid,
    input  logic [W-1:0]   prng_out_rnd,
    output logic           prng_out_ready,
    output logic [RND-1:0] rnd_out,
    output logic           rnd_valid,
    input  logic           rnd_consume,
    input  logic           flush,
    output logic [1:0]     fill_level,
    output logic           underflow
);
    localparam int NBEATS = RND / W;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (RND % W != 0) begin : g_width_check
        $error("prng_rnd_feeder: RND must be a multiple of W");
    end

    logic [RND-1:0] entry_q [2];
    logic [RND-1:0] entry_d [2];
    logic [1:0]     full_q, full_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           underflow_q, underflow_d;
    logic [1:0]     fill_level_q, fill_level_d;
    logic           ready_en_q;
    logic           accept;
    logic           last_beat;

    // ready_en_q keeps the PRNG stalled until the first edge after reset release.
    assign prng_out_ready = ready_en_q & ~full_q[wr_ptr_q] & ~flush;
    assign accept         = prng_out_valid & prng_out_ready;
    assign last_beat      = (beat_cnt_q == CW'(NBEATS - 1));

    always_comb begin
        entry_d     = entry_q;
        full_d      = full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        underflow_d = underflow_q;
        if (flush) begin
            full_d      = '0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            beat_cnt_d  = '0;
            underflow_d = 1'b0;
`ifdef RND_FEEDER_ZEROIZE_EN
            entry_d[0]  = '0;
            entry_d[1]  = '0;
`endif
        end else begin
            if (accept) begin
                entry_d[wr_ptr_q][beat_cnt_q*W +: W] = prng_out_rnd;
                if (last_beat) begin
                    beat_cnt_d       = '0;
                    full_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d         = ~wr_ptr_q;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            // A completing write always targets the other entry, so both updates can coexist.
            if (rnd_consume) begin
                if (full_q[rd_ptr_q]) begin
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
`ifdef RND_FEEDER_ZEROIZE_EN
                    entry_d[rd_ptr_q] = '0;
`endif
                end else begin
                    underflow_d = 1'b1;
                end
            end
        end
        fill_level_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q[0]   <= '0;
            entry_q[1]   <= '0;
            full_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            beat_cnt_q   <= '0;
            underflow_q  <= 1'b0;
            fill_level_q <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            full_q       <= full_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            underflow_q  <= underflow_d;
            fill_level_q <= fill_level_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign rnd_valid  = full_q[rd_ptr_q];
    assign fill_level = fill_level_q;
    assign underflow  = underflow_q;
`ifdef RND_FEEDER_ZEROIZE_EN
    assign rnd_out = full_q[rd_ptr_q] ? entry_q[rd_ptr_q] : '0;
`else
    assign rnd_out = entry_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_prng_rnd_feeder.sv
// Randomized and directed bench for prng_rnd_feeder (RND=8, W=4) with a queue-based reference model and a consume-side scoreboard.
module tb_prng_rnd_feeder;
    localparam int RND_T = 8;
    localparam int W_T   = 4;
    localparam int NB    = RND_T / W_T;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             prng_out_valid = 1'b0;
    logic [W_T-1:0]   prng_out_rnd = '0;
    logic             prng_out_ready;
    logic [RND_T-1:0] rnd_out;
    logic             rnd_valid;
    logic             rnd_consume = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       fill_level;
    logic             underflow;

    prng_rnd_feeder #(.RND(RND_T), .W(W_T)) dut (
        .clk            (clk),
        .rst            (rst),
        .prng_out_valid (prng_out_valid),
        .prng_out_rnd   (prng_out_rnd),
        .prng_out_ready (prng_out_ready),
        .rnd_out        (rnd_out),
        .rnd_valid      (rnd_valid),
        .rnd_consume    (rnd_consume),
        .flush          (flush),
        .fill_level     (fill_level),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: complete entries awaiting use, partially collected beats, flags.
    logic [RND_T-1:0] model_q[$];
    logic [RND_T-1:0] exp_q[$];
    logic [W_T-1:0]   part[$];
    bit               rdy_en_m = 1'b0;
    bit               uf_m = 1'b0;
    bit               rdy_m;
    logic [RND_T-1:0] ent_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete(); exp_q.delete(); part.delete();
            rdy_en_m = 1'b0;
            uf_m     = 1'b0;
        end else begin
            rdy_m = rdy_en_m && (model_q.size() < 2) && !flush;
            if (flush) begin
                model_q.delete(); exp_q.delete(); part.delete();
                uf_m = 1'b0;
            end else begin
                if (rnd_consume) begin
                    if (model_q.size() > 0) void'(model_q.pop_front());
                    else uf_m = 1'b1;
                end
                if (prng_out_valid && rdy_m) begin
                    part.push_back(prng_out_rnd);
                    if (part.size() == NB) begin
                        ent_m = '0;
                        foreach (part[i]) ent_m = ent_m | (RND_T'(part[i]) << (i * W_T));
                        model_q.push_back(ent_m);
                        exp_q.push_back(ent_m);
                        part.delete();
                    end
                end
            end
            rdy_en_m = 1'b1;
        end
    end

    // Monitor: status compared every cycle; data popped from the scoreboard on each real consume.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", 32'(prng_out_ready), 32'(rdy_en_m && (model_q.size() < 2) && !flush));
            check("rnd_valid", 32'(rnd_valid), 32'(model_q.size() > 0));
            check("fill_level", 32'(fill_level), 32'(model_q.size()));
            check("underflow", 32'(underflow), 32'(uf_m));
`ifdef RND_FEEDER_ZEROIZE_EN
            if (!rnd_valid) check("zeroized_out", 32'(rnd_out), 32'h0);
`endif
            if (rnd_consume && rnd_valid && !flush) begin
                if (exp_q.size() == 0) check("consume_unexpected", 32'(rnd_out), 32'hFFFF_FFFF);
                else check("consume_data", 32'(rnd_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input bit v, input logic [W_T-1:0] d, input bit c, input bit f);
        prng_out_valid = v;
        prng_out_rnd   = d;
        rnd_consume    = c;
        flush          = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ready", 32'(prng_out_ready), 32'h0);
        check("reset_rnd_out", 32'(rnd_out), 32'h0);
        step(0, 4'h0, 0, 0);

        // Two beats form one entry, low slice first.
        step(1, 4'hA, 0, 0);
        step(1, 4'h5, 0, 0);
        check("t1_valid", 32'(rnd_valid), 32'h1);
        check("t1_rnd_out", 32'(rnd_out), 32'h5A);
        check("t1_fill", 32'(fill_level), 32'h1);
        step(0, 4'h0, 1, 0);

        // Fill both entries, stall, then drain one.
        step(1, 4'h1, 0, 0);
        step(1, 4'h2, 0, 0);
        step(1, 4'h3, 0, 0);
        step(1, 4'h4, 0, 0);
        check("t2_ready_full", 32'(prng_out_ready), 32'h0);
        check("t2_fill", 32'(fill_level), 32'h2);
        check("t2_rnd_out", 32'(rnd_out), 32'h21);
        step(1, 4'hF, 0, 0);
        step(0, 4'h0, 1, 0);
        check("t2_rnd_out_next", 32'(rnd_out), 32'h43);
        check("t2_ready_after", 32'(prng_out_ready), 32'h1);
        step(0, 4'h0, 1, 0);

        // Underflow is sticky until flush.
        step(0, 4'h0, 1, 0);
        check("t3_underflow", 32'(underflow), 32'h1);
        check("t3_fill", 32'(fill_level), 32'h0);
        step(0, 4'h0, 0, 1);
        check("t3_underflow_clr", 32'(underflow), 32'h0);

        // Completion and consume on the same edge.
        step(1, 4'h6, 0, 0);
        step(1, 4'h7, 0, 0);
        step(1, 4'h8, 0, 0);
        step(1, 4'h9, 1, 0);
        check("t4_fill", 32'(fill_level), 32'h1);
        check("t4_rnd_out", 32'(rnd_out), 32'h98);
        step(0, 4'h0, 1, 0);

        // Flush drops a partial entry.
        step(1, 4'h7, 0, 0);
        step(0, 4'h0, 0, 1);
        step(1, 4'h1, 0, 0);
        step(1, 4'h2, 0, 0);
        check("t5_rnd_out", 32'(rnd_out), 32'h21);
        step(0, 4'h0, 1, 0);

        // Asynchronous reset mid-assembly takes effect without a clock edge.
        step(1, 4'h3, 0, 0);
        step(1, 4'h4, 0, 0);
        step(1, 4'h5, 0, 0);
        prng_out_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(rnd_valid), 32'h0);
        check("t6_fill", 32'(fill_level), 32'h0);
        check("t6_ready", 32'(prng_out_ready), 32'h0);
        check("t6_rnd_out", 32'(rnd_out), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(0, 4'h0, 0, 0);
        step(1, 4'hE, 0, 0);
        step(1, 4'hF, 0, 0);
        check("t6_after_reset", 32'(rnd_out), 32'hFE);
        step(0, 4'h0, 1, 0);

        // Random soak without flush: every entry must be consumed once, in order.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 99) < 70, 4'($urandom), (model_q.size() > 0) && ($urandom_range(0, 1) == 1), 0);
        end
        for (int i = 0; i < 8 && model_q.size() > 0; i++) step(0, 4'h0, 1, 0);
        step(0, 4'h0, 0, 0);
        check("soak_underflow", 32'(underflow), 32'h0);
        check("soak_drained", 32'(exp_q.size()), 32'h0);
        check("soak_empty", 32'(rnd_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
